// File: rtl/arm_mem_pkg.sv
// arm_mem_pkg
//   Shared definitions for the SRAM arbiter: FSM state encoding, the owner
//   encoding of the granted pipeline port, and the halfword select values
//   used as the SRAM address LSB.
package arm_mem_pkg;

  // Arbiter FSM states: idle, low halfword phase, high halfword phase, done.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } arb_state_t;

  // Owner of the current SRAM transaction.
  localparam logic OWN_IF  = 1'b0;
  localparam logic OWN_MEM = 1'b1;

  // Halfword select appended to the latched word address.
  localparam logic HALF_LO = 1'b0;
  localparam logic HALF_HI = 1'b1;

endpackage : arm_mem_pkg

// File: rtl/sram_arbiter.sv
// sram_arbiter
//   Shares one 16-bit asynchronous SRAM between the instruction-fetch port
//   and the data port. Each 32-bit word access is split into a low and a
//   high halfword phase, each lasting WAIT_CYCLES clocks. The data port has
//   fixed priority over fetch. Completion is signalled by one-cycle ready
//   pulses; every SRAM-facing output is registered.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   if_req, if_addr          fetch request (held until if_ready), byte address
//   if_rdata, if_ready       fetched word, one-cycle completion pulse
//   mem_rd_en, mem_wr_en     data read / write request (mutually exclusive)
//   mem_addr, mem_wdata      data byte address, write data
//   mem_rdata, mem_ready     read word, one-cycle completion pulse
//   mem_stall                combinational: data request not yet completed
//   sram_addr                halfword address to the SRAM
//   sram_dq_out, sram_dq_oe  write data to the pad and its output enable
//   sram_dq_in               read data from the pad
//   sram_we_n                write strobe, active-low
module sram_arbiter
  import arm_mem_pkg::*;
#(
  parameter int SRAM_AW     = 18,
  parameter int WAIT_CYCLES = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               if_req,
  input  logic [31:0]        if_addr,
  output logic [31:0]        if_rdata,
  output logic               if_ready,
  input  logic               mem_rd_en,
  input  logic               mem_wr_en,
  input  logic [31:0]        mem_addr,
  input  logic [31:0]        mem_wdata,
  output logic [31:0]        mem_rdata,
  output logic               mem_ready,
  output logic               mem_stall,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_dq_out,
  output logic               sram_dq_oe,
  input  logic [15:0]        sram_dq_in,
  output logic               sram_we_n
);

  localparam logic [3:0] LP_LAST = 4'(WAIT_CYCLES - 1);

  // Transaction state
  arb_state_t         r_state, w_state_nxt;
  logic [3:0]         r_cnt, w_cnt_nxt;
  logic               r_owner, w_owner_nxt;
  logic               r_write, w_write_nxt;
  logic [SRAM_AW-2:0] r_word, w_word_nxt;
  logic [31:0]        r_wdata, w_wdata_nxt;
  logic [15:0]        r_lo_half, w_lo_half_nxt;

  // Registered outputs
  logic [31:0]        r_if_rdata, w_if_rdata_nxt;
  logic [31:0]        r_mem_rdata, w_mem_rdata_nxt;
  logic               r_if_ready, w_if_ready_nxt;
  logic               r_mem_ready, w_mem_ready_nxt;
  logic [SRAM_AW-1:0] r_sram_addr, w_sram_addr_nxt;
  logic [15:0]        r_dq_out, w_dq_out_nxt;
  logic               r_dq_oe, w_dq_oe_nxt;
  logic               r_we_n, w_we_n_nxt;

  logic               w_last;
  logic               w_phase_nxt;
  logic               w_unused;

  assign w_last = (r_cnt == LP_LAST);

  // Byte-offset and upper address bits do not take part in SRAM addressing.
  assign w_unused = ^{if_addr[31:SRAM_AW+1], if_addr[1:0],
                      mem_addr[31:SRAM_AW+1], mem_addr[1:0]};

  // Next-state logic: arbitration, latching on grant, phase counting, read capture.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_owner_nxt     = r_owner;
    w_write_nxt     = r_write;
    w_word_nxt      = r_word;
    w_wdata_nxt     = r_wdata;
    w_lo_half_nxt   = r_lo_half;
    w_if_rdata_nxt  = r_if_rdata;
    w_mem_rdata_nxt = r_mem_rdata;
    case (r_state)
      IDLE: begin
        if (mem_rd_en | mem_wr_en) begin
          w_state_nxt = LO;
          w_cnt_nxt   = 4'd0;
          w_owner_nxt = OWN_MEM;
          w_write_nxt = mem_wr_en;
          w_word_nxt  = mem_addr[SRAM_AW:2];
          w_wdata_nxt = mem_wdata;
        end else if (if_req) begin
          w_state_nxt = LO;
          w_cnt_nxt   = 4'd0;
          w_owner_nxt = OWN_IF;
          w_write_nxt = 1'b0;
          w_word_nxt  = if_addr[SRAM_AW:2];
        end else begin
          w_state_nxt = IDLE;
        end
      end
      LO: begin
        if (w_last) begin
          w_state_nxt = HI;
          w_cnt_nxt   = 4'd0;
          if (!r_write) begin
            w_lo_half_nxt = sram_dq_in;
          end else begin
            w_lo_half_nxt = r_lo_half;
          end
        end else begin
          w_cnt_nxt = r_cnt + 4'd1;
        end
      end
      HI: begin
        if (w_last) begin
          w_state_nxt = DONE;
          w_cnt_nxt   = 4'd0;
          // The high half arrives on the same edge that publishes the word.
          if (!r_write && (r_owner == OWN_IF)) begin
            w_if_rdata_nxt = {sram_dq_in, r_lo_half};
          end else if (!r_write) begin
            w_mem_rdata_nxt = {sram_dq_in, r_lo_half};
          end else begin
            w_if_rdata_nxt = r_if_rdata;
          end
        end else begin
          w_cnt_nxt = r_cnt + 4'd1;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = 4'd0;
      end
    endcase
  end

  // Output decode from the upcoming state so every pad signal is a flop.
  always_comb begin
    w_phase_nxt     = (w_state_nxt == LO) || (w_state_nxt == HI);
    w_sram_addr_nxt = r_sram_addr;
    w_dq_out_nxt    = 16'h0000;
    case (w_state_nxt)
      LO: begin
        w_sram_addr_nxt = {w_word_nxt, HALF_LO};
        w_dq_out_nxt    = w_write_nxt ? w_wdata_nxt[15:0] : 16'h0000;
      end
      HI: begin
        w_sram_addr_nxt = {w_word_nxt, HALF_HI};
        w_dq_out_nxt    = w_write_nxt ? w_wdata_nxt[31:16] : 16'h0000;
      end
      default: begin
        w_sram_addr_nxt = r_sram_addr;
        w_dq_out_nxt    = 16'h0000;
      end
    endcase
    w_dq_oe_nxt = w_phase_nxt & w_write_nxt;
    // Strobe skips the first and last cycle of a phase for address setup/hold.
    w_we_n_nxt = ~(w_phase_nxt & w_write_nxt &
                   (w_cnt_nxt != 4'd0) & (w_cnt_nxt != LP_LAST));
    w_if_ready_nxt  = (w_state_nxt == DONE) && (w_owner_nxt == OWN_IF);
    w_mem_ready_nxt = (w_state_nxt == DONE) && (w_owner_nxt == OWN_MEM);
  end

  // State and output registers; reset aborts any transaction immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= 4'd0;
      r_owner     <= OWN_IF;
      r_write     <= 1'b0;
      r_word      <= '0;
      r_wdata     <= 32'h0000_0000;
      r_lo_half   <= 16'h0000;
      r_if_rdata  <= 32'h0000_0000;
      r_mem_rdata <= 32'h0000_0000;
      r_if_ready  <= 1'b0;
      r_mem_ready <= 1'b0;
      r_sram_addr <= '0;
      r_dq_out    <= 16'h0000;
      r_dq_oe     <= 1'b0;
      r_we_n      <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_owner     <= w_owner_nxt;
      r_write     <= w_write_nxt;
      r_word      <= w_word_nxt;
      r_wdata     <= w_wdata_nxt;
      r_lo_half   <= w_lo_half_nxt;
      r_if_rdata  <= w_if_rdata_nxt;
      r_mem_rdata <= w_mem_rdata_nxt;
      r_if_ready  <= w_if_ready_nxt;
      r_mem_ready <= w_mem_ready_nxt;
      r_sram_addr <= w_sram_addr_nxt;
      r_dq_out    <= w_dq_out_nxt;
      r_dq_oe     <= w_dq_oe_nxt;
      r_we_n      <= w_we_n_nxt;
    end
  end

  assign if_rdata    = r_if_rdata;
  assign if_ready    = r_if_ready;
  assign mem_rdata   = r_mem_rdata;
  assign mem_ready   = r_mem_ready;
  assign mem_stall   = (mem_rd_en | mem_wr_en) & ~r_mem_ready;
  assign sram_addr   = r_sram_addr;
  assign sram_dq_out = r_dq_out;
  assign sram_dq_oe  = r_dq_oe;
  assign sram_we_n   = r_we_n;

endmodule : sram_arbiter

// File: doc/sram_arbiter.md
# sram_arbiter

Shares one 16-bit asynchronous SRAM between the pipeline's instruction-fetch port (IF stage) and data port (MEM stage). Each 32-bit word access becomes two halfword SRAM accesses, each stretched over a programmable number of wait cycles. The data port has fixed priority over fetch. Single-cycle ready pulses let the pipeline top derive its freeze signal.

## Interface
- `SRAM_AW`, 18: SRAM halfword address width.
- `WAIT_CYCLES`, 3: clocks per halfword phase; legal range 2..15.
- `clk` in 1: clock; all state changes on the rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `if_req` in 1: fetch request, held until `if_ready`.
- `if_addr` in 32: fetch byte address; bits [1:0] ignored.
- `if_rdata` out 32: fetched word, valid when `if_ready`=1.
- `if_ready` out 1: one-cycle completion pulse for fetch.
- `mem_rd_en` in 1: data read request.
- `mem_wr_en` in 1: data write request. Never asserted together with `mem_rd_en`.
- `mem_addr` in 32: data byte address; bits [1:0] ignored.
- `mem_wdata` in 32: write data.
- `mem_rdata` out 32: read word, valid when `mem_ready`=1.
- `mem_ready` out 1: one-cycle completion pulse for data.
- `mem_stall` out 1: combinational, `(mem_rd_en|mem_wr_en) & ~mem_ready`.
- `sram_addr` out SRAM_AW: halfword address.
- `sram_dq_out` out 16: write data to the pad.
- `sram_dq_oe` out 1: pad output enable.
- `sram_dq_in` in 16: read data from the pad.
- `sram_we_n` out 1: write strobe, active-low.

## Operation
- FSM states are IDLE, LO, HI, DONE.
- **IDLE:**
  - If `mem_rd_en|mem_wr_en`, grant MEM; otherwise, if `if_req`, grant IF; otherwise stay in IDLE.
  - On grant, latch the owner, the op (read/write), `addr[SRAM_AW:2]` and `wdata`, clear the wait counter, and go to LO.
- **LO and HI:**
  - Each phase lasts exactly WAIT_CYCLES cycles. The counter runs 0..WAIT_CYCLES-1; on the last count the state advances (LO→HI, HI→DONE).
  - `sram_addr` = {latched word addr, 0} in LO and {latched word addr, 1} in HI.
  - On a read, capture `sram_dq_in` on the last cycle of the phase: LO fills bits [15:0], HI fills bits [31:16].
  - On a write, `sram_dq_oe`=1 for the whole phase. `sram_dq_out` = wdata[15:0] in LO and wdata[31:16] in HI. `sram_we_n`=0 on every cycle of the phase except the first and the last, which gives address setup and hold.
- **DONE:**
  - Lasts one cycle. Assert the granted owner's ready and drive its rdata (the assembled word on a read, unchanged on a write).
  - Then go to IDLE. At least one IDLE cycle separates transactions.
- Requests and addresses changing after grant are ignored; the latched copy is used.
- A request withdrawn mid-transaction still completes, and its ready pulse is harmless.
- The `rdata` outputs hold their last value between pulses.
- Starvation: IF can lose arbitration only while MEM requests are pending. The pipeline freezes on `mem_stall`, so IF is served after that single MEM access.

## Timing
- Reset values (asynchronous, immediate even mid-transaction):
  - state=IDLE, counter=0.
  - `if_ready`=0, `mem_ready`=0, `if_rdata`=0, `mem_rdata`=0.
  - `sram_addr`=0, `sram_dq_out`=0, `sram_dq_oe`=0, `sram_we_n`=1.
- Any in-flight write is aborted without further strobes.
- Latency: a request present in IDLE at edge 0 gets its ready high in cycle 2·WAIT_CYCLES+1. With the default that is cycle 7.
- Throughput: one word per 2·WAIT_CYCLES+2 cycles under continuous requests.
- Simultaneous IF and MEM requests in IDLE: MEM is served first. IF is granted at the IDLE following MEM's DONE, provided `if_req` is still held.
- All SRAM outputs come from registers (glitch-free `sram_we_n`). Only `mem_stall` is combinational.

## Structure
- The shared package `arm_mem_pkg` holds:
  - the state enum (IDLE, LO, HI, DONE);
  - the owner encoding (OWN_IF=0, OWN_MEM=1);
  - the halfword select constants.
- The block is a single module. The wait counter is inline (4 bits); no sub-module is needed.
- The pipeline top drives `freeze` from `if_req & ~if_ready` OR `mem_stall`.

## Test plan
- **Reset:** hold `rst`=1 → every output is at its reset value. Assert `rst` in the middle of the LO phase of a write → `sram_we_n`=1 and state is IDLE in the same cycle.
- **Fetch read:** `if_req`=1, `if_addr`=0x0000_0010. SRAM model returns 0x5678 at halfword 0x8 and 0x1234 at halfword 0x9 → `sram_addr` is 0x8 for 3 cycles then 0x9 for 3 cycles; `if_ready` pulses at cycle 7 with `if_rdata`=0x1234_5678.
- **Data write:** `mem_wr_en`=1, `mem_addr`=0x20, `mem_wdata`=0xDEAD_BEEF → halfword 0x10 receives 0xBEEF and halfword 0x11 receives 0xDEAD; `sram_we_n` is low only in the middle cycle of each phase; `mem_ready` pulses once.
- **Conflict:** `if_req` and `mem_rd_en` assert in the same IDLE cycle → MEM completes at cycle 7 and IF completes at cycle 15; `mem_stall`=1 on cycles 0–6.
- **Address change:** change `if_addr` during HI → the fetched word comes from the originally latched address.
- **WAIT_CYCLES=2:** back-to-back fetches → ready pulses arrive every 6 cycles, and `sram_we_n` stays 1 throughout.
